pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 93 +++++++++
 tb/tb_pipe_skid_reg.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register: a main output stage plus one skid slot. All outputs
// come straight from flops, so there is no combinational path from input to output.
module pipe_skid_reg #(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             softReset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       count
);

  // Encoding: bit0 = main valid, bit1 = skid valid.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             load_main_in, load_main_skid, load_skid;
  logic             in_xfer, out_xfer;

  assign in_ready  = ~state[1];
  assign out_valid = state[0];
  assign out_data  = main_q;
  assign count     = {state[1], state[0] & ~state[1]};

  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          load_main_in = 1'b1;
          state_nxt    = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_main_in = 1'b1;
        end else if (in_xfer) begin
          load_skid = 1'b1;
          state_nxt = FULL;
        end else if (out_xfer) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          load_main_skid = 1'b1;
          state_nxt      = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // Flush drops both handshakes but leaves the payload registers untouched.
    if (softReset) begin
      state_nxt      = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_nxt;
      if (load_main_in)
        main_q <= in_data;
      else if (load_main_skid)
        main_q <= skid_q;
      if (load_skid)
        skid_q <= in_data;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios on a 9-bit instance, then a
// random handshake stress with a queue scoreboard on 1-bit and 64-bit instances.
module tb_pipe_skid_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  // 9-bit directed instance
  logic       sr = 1'b0, iv = 1'b0, ordy = 1'b0;
  logic [8:0] id = '0;
  logic       irdy, ov;
  logic [8:0] od;
  logic [1:0] cnt;

  // 1-bit stress instance
  logic       iv1 = 1'b0, ordy1 = 1'b0;
  logic [0:0] id1 = '0, od1;
  logic       irdy1, ov1;
  logic [1:0] cnt1;

  // 64-bit stress instance
  logic        iv64 = 1'b0, ordy64 = 1'b0;
  logic [63:0] id64 = '0, od64;
  logic        irdy64, ov64;
  logic [1:0]  cnt64;

  pipe_skid_reg #(.WIDTH(9)) dut9 (
    .clk(clk), .reset(rst), .softReset(sr), .in_valid(iv), .in_data(id),
    .in_ready(irdy), .out_valid(ov), .out_data(od), .out_ready(ordy), .count(cnt)
  );

  pipe_skid_reg #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(rst), .softReset(1'b0), .in_valid(iv1), .in_data(id1),
    .in_ready(irdy1), .out_valid(ov1), .out_data(od1), .out_ready(ordy1), .count(cnt1)
  );

  pipe_skid_reg #(.WIDTH(64)) dut64 (
    .clk(clk), .reset(rst), .softReset(1'b0), .in_valid(iv64), .in_data(id64),
    .in_ready(irdy64), .out_valid(ov64), .out_data(od64), .out_ready(ordy64), .count(cnt64)
  );

  int unsigned checks = 0;
  int unsigned passes = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] q1[$];
  logic [63:0] q64[$];
  logic [63:0] head;

  initial begin
    // Reset with a live input: nothing may be captured.
    #1;
    rst = 1'b1; iv = 1'b1; id = 9'h1AB; sr = 1'b1;
    tick();
    rst = 1'b0; iv = 1'b0; sr = 1'b0;
    check("rst_ov",   64'(ov),   64'd0);
    check("rst_irdy", 64'(irdy), 64'd1);
    check("rst_cnt",  64'(cnt),  64'd0);
    check("rst_od",   64'(od),   64'd0);

    // Streaming at full rate.
    ordy = 1'b1;
    for (int unsigned w = 1; w <= 3; w++) begin
      iv = 1'b1; id = 9'(w);
      tick();
      check("strm_od",   64'(od),   64'(w));
      check("strm_ov",   64'(ov),   64'd1);
      check("strm_irdy", 64'(irdy), 64'd1);
      check("strm_cnt",  64'(cnt),  64'd1);
    end
    iv = 1'b0;
    tick();
    check("strm_drain", 64'(cnt), 64'd0);

    // Backpressure: 5 and 6 stored, 7 refused.
    ordy = 1'b0; iv = 1'b1; id = 9'd5;
    tick();
    check("bp_cnt1", 64'(cnt), 64'd1);
    id = 9'd6;
    tick();
    check("bp_cnt2",  64'(cnt),  64'd2);
    check("bp_irdy0", 64'(irdy), 64'd0);
    check("bp_od5",   64'(od),   64'd5);
    id = 9'd7;
    tick();
    check("bp_refuse_cnt", 64'(cnt), 64'd2);
    check("bp_refuse_od",  64'(od),  64'd5);
    iv = 1'b0; ordy = 1'b1;
    tick();
    check("bp_od6",  64'(od),  64'd6);
    check("bp_cnt3", 64'(cnt), 64'd1);
    tick();
    check("bp_empty_cnt", 64'(cnt), 64'd0);
    check("bp_empty_ov",  64'(ov),  64'd0);

    // Flush while FULL with handshakes active on both sides.
    ordy = 1'b0; iv = 1'b1; id = 9'd5;
    tick();
    id = 9'd6;
    tick();
    check("fl_full", 64'(cnt), 64'd2);
    sr = 1'b1; iv = 1'b1; id = 9'd7; ordy = 1'b1;
    tick();
    sr = 1'b0; iv = 1'b0;
    check("fl_cnt",  64'(cnt),  64'd0);
    check("fl_ov",   64'(ov),   64'd0);
    check("fl_irdy", 64'(irdy), 64'd1);
    check("fl_data_kept", 64'(od), 64'd5);
    tick();
    check("fl_discard_ov", 64'(ov), 64'd0);

    // Simultaneous input and output transfer in ONE.
    ordy = 1'b0; iv = 1'b1; id = 9'd8;
    tick();
    check("sim_od8", 64'(od), 64'd8);
    id = 9'd9; ordy = 1'b1;
    tick();
    iv = 1'b0;
    check("sim_od9", 64'(od),  64'd9);
    check("sim_cnt", 64'(cnt), 64'd1);
    tick();
    check("sim_empty", 64'(cnt), 64'd0);

    // Hard reset mid-operation from FULL, softReset also high.
    ordy = 1'b0; iv = 1'b1; id = 9'h0AA;
    tick();
    id = 9'h055;
    tick();
    check("mrst_full", 64'(cnt), 64'd2);
    rst = 1'b1; sr = 1'b1;
    tick();
    rst = 1'b0; sr = 1'b0; iv = 1'b0;
    check("mrst_cnt",  64'(cnt),  64'd0);
    check("mrst_ov",   64'(ov),   64'd0);
    check("mrst_irdy", 64'(irdy), 64'd1);
    check("mrst_od",   64'(od),   64'd0);

    // Random stress on both widths, scoreboard per instance.
    for (int unsigned c = 0; c < 10000; c++) begin
      iv1    = 1'($urandom_range(0, 1));
      ordy1  = 1'($urandom_range(0, 1));
      id1    = 1'($urandom_range(0, 1));
      iv64   = 1'($urandom_range(0, 1));
      ordy64 = 1'($urandom_range(0, 1));
      id64   = {$urandom, $urandom};
      check("w1_cnt",  64'(cnt1),  64'(q1.size()));
      check("w64_cnt", 64'(cnt64), 64'(q64.size()));
      if (ov1 && ordy1) begin
        head = (q1.size() > 0) ? q1.pop_front() : 64'hDEAD;
        check("w1_data", 64'(od1), head);
      end
      if (iv1 && irdy1) q1.push_back(64'(id1));
      if (ov64 && ordy64) begin
        head = (q64.size() > 0) ? q64.pop_front() : ~od64;
        check("w64_data", od64, head);
      end
      if (iv64 && irdy64) q64.push_back(id64);
      tick();
    end
    // Drain and confirm nothing is left behind.
    iv1 = 1'b0; iv64 = 1'b0; ordy1 = 1'b1; ordy64 = 1'b1;
    for (int unsigned c = 0; c < 3; c++) begin
      if (ov1) begin
        head = (q1.size() > 0) ? q1.pop_front() : 64'hDEAD;
        check("w1_drain", 64'(od1), head);
      end
      if (ov64) begin
        head = (q64.size() > 0) ? q64.pop_front() : ~od64;
        check("w64_drain", od64, head);
      end
      tick();
    end
    check("w1_left",  64'(q1.size()),  64'd0);
    check("w64_left", 64'(q64.size()), 64'd0);
    check("w1_end_cnt",  64'(cnt1),  64'd0);
    check("w64_end_cnt", 64'(cnt64), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
